// File: rtl/tbu_sched_if.sv
// Write handshake, survivor RAM strobes and TBU controls of the traceback scheduler.
interface tbu_sched_if #(parameter int AW = 3);
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic [1:0]    wr_bank;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_bank_warm;
    logic [1:0]    rd_bank_dec;
    logic          tbu_enable;
    logic          tbu_selection;
    logic          block_done;
    logic          busy;

    modport master (
        output in_valid,
        input  in_ready, wr_en, wr_bank, wr_addr, rd_en, rd_addr,
               rd_bank_warm, rd_bank_dec, tbu_enable, tbu_selection,
               block_done, busy
    );

    modport slave (
        input  in_valid,
        output in_ready, wr_en, wr_bank, wr_addr, rd_en, rd_addr,
               rd_bank_warm, rd_bank_dec, tbu_enable, tbu_selection,
               block_done, busy
    );
endinterface

// File: rtl/tbu_sched.sv
// Survivor-memory bank scheduler: fills 4 banks in order and runs warm-up/decode
// traceback jobs over each pair of consecutive full banks.
//
// state | meaning
// IDLE  | no job; waits for banks db and db+1 to be full
// WARM  | reads bank db+1 top-down, TBU in warm-up
// DEC   | reads bank db top-down, TBU emits bits; releases bank db at the end
module tbu_sched #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input logic       clk,
    input logic       rst,
    tbu_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WARM, DEC} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state, state_nxt;
    logic [3:0]    full, set_mask, clr_mask;
    logic [1:0]    wr_bank, db, db_next;
    logic [AW-1:0] wr_addr, rd_cnt, rd_cnt_nxt;
    logic          in_ready, wr_en, wr_last, release_bank;
    logic          tbu_enable, tbu_selection, block_done;

    assign in_ready = !full[wr_bank];
    assign wr_en    = bus.in_valid & in_ready;
    assign wr_last  = wr_en && (wr_addr == LAST);
    assign db_next  = db + 2'd1;

    // The bank being written is never full, so set and clear never hit the same bank.
    assign set_mask = wr_last      ? (4'b0001 << wr_bank) : 4'b0000;
    assign clr_mask = release_bank ? (4'b0001 << db)      : 4'b0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank <= '0;
            wr_addr <= '0;
            full    <= '0;
        end else begin
            full <= (full | set_mask) & ~clr_mask;
            if (wr_en) begin
                if (wr_last) begin
                    wr_addr <= '0;
                    wr_bank <= wr_bank + 2'd1;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        rd_cnt_nxt   = rd_cnt;
        release_bank = 1'b0;
        case (state)
            IDLE: begin
                if (full[db] && full[db_next]) begin
                    state_nxt  = WARM;
                    rd_cnt_nxt = LAST;
                end
            end
            WARM: begin
                rd_cnt_nxt = rd_cnt - 1'b1;
                if (rd_cnt == '0) begin
                    state_nxt  = DEC;
                    rd_cnt_nxt = LAST;
                end
            end
            DEC: begin
                rd_cnt_nxt = rd_cnt - 1'b1;
                if (rd_cnt == '0) begin
                    state_nxt    = IDLE;
                    rd_cnt_nxt   = '0;
                    release_bank = 1'b1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                rd_cnt_nxt = '0;
            end
        endcase
    end

    // TBU controls lag the read strobe by one cycle to line up with the RAM data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rd_cnt        <= '0;
            db            <= '0;
            tbu_enable    <= 1'b0;
            tbu_selection <= 1'b0;
            block_done    <= 1'b0;
        end else begin
            state         <= state_nxt;
            rd_cnt        <= rd_cnt_nxt;
            tbu_enable    <= (state != IDLE);
            tbu_selection <= (state == DEC);
            block_done    <= release_bank;
            if (release_bank) begin
                db <= db_next;
            end
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.wr_en         = wr_en;
    assign bus.wr_bank       = wr_bank;
    assign bus.wr_addr       = wr_addr;
    assign bus.rd_en         = (state != IDLE);
    assign bus.rd_addr       = rd_cnt;
    assign bus.rd_bank_warm  = db_next;
    assign bus.rd_bank_dec   = db;
    assign bus.tbu_enable    = tbu_enable;
    assign bus.tbu_selection = tbu_selection;
    assign bus.block_done    = block_done;
    assign bus.busy          = (state != IDLE);
endmodule

// File: tb/tb_tbu_sched.sv
// Scoreboard bench for tbu_sched: a timeline model predicts writes, read beats,
// TBU controls and block_done; a separate checker pops and compares each cycle.
module tb_tbu_sched;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tbu_sched_if #(.AW(AW)) bus ();
    tbu_sched #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { int cyc; int addr; int warm; int dec; bit sel; } beat_t;
    typedef struct { bit ready; bit wen; int bank; int addr; } wrec_t;

    beat_t rq[$];
    beat_t tq[$];
    int    dq[$];
    wrec_t wq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // model state
    int    n_wr;
    int    n_jobs;
    int    fill  [0:255];
    int    start [0:255];
    int    m_k, m_j, m_s;
    bit    m_rdy;
    wrec_t m_w;
    beat_t m_b;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference model: bank k%4 of block k is reusable once job k-4 has read its
    // last decode beat; job j starts 2 cycles after block j+1 fills, but never
    // sooner than 2 cycles after job j-1's final read.
    initial begin
        n_wr   = 0;
        n_jobs = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                n_wr   = 0;
                n_jobs = 0;
                rq.delete();
                tq.delete();
                dq.delete();
                wq.delete();
            end else begin
                m_k   = n_wr / DEPTH;
                m_rdy = (m_k < 4) ||
                        ((m_k - 4) < n_jobs && cyc >= start[m_k-4] + 2*DEPTH);
                m_w.ready = m_rdy;
                m_w.wen   = bus.in_valid && m_rdy;
                m_w.bank  = m_k % 4;
                m_w.addr  = n_wr % DEPTH;
                wq.push_back(m_w);
                if (m_w.wen) begin
                    n_wr++;
                    if (n_wr % DEPTH == 0) begin
                        fill[m_k] = cyc;
                        if (m_k >= 1) begin
                            m_j = m_k - 1;
                            m_s = fill[m_k] + 2;
                            if (m_j > 0 && start[m_j-1] + 2*DEPTH + 1 > m_s)
                                m_s = start[m_j-1] + 2*DEPTH + 1;
                            start[m_j] = m_s;
                            n_jobs     = m_j + 1;
                            for (int i = 0; i < 2*DEPTH; i++) begin
                                m_b.cyc  = m_s + i;
                                m_b.addr = DEPTH - 1 - (i % DEPTH);
                                m_b.warm = (m_j + 1) % 4;
                                m_b.dec  = m_j % 4;
                                m_b.sel  = (i >= DEPTH);
                                rq.push_back(m_b);
                                m_b.cyc = m_s + i + 1;
                                tq.push_back(m_b);
                            end
                            dq.push_back(m_s + 2*DEPTH);
                        end
                    end
                end
            end
        end
    end

    // Checker: sampled 1 time unit after the falling edge.
    wrec_t c_w;
    beat_t c_b;
    bit    c_exp;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst && wq.size() > 0) begin
                c_w = wq.pop_front();
                chk("in_ready", int'(bus.in_ready), int'(c_w.ready));
                chk("wr_en", int'(bus.wr_en), int'(c_w.wen));
                if (c_w.wen && bus.wr_en) begin
                    chk("wr_bank", int'(bus.wr_bank), c_w.bank);
                    chk("wr_addr", int'(bus.wr_addr), c_w.addr);
                end

                while (rq.size() > 0 && rq[0].cyc < cyc) void'(rq.pop_front());
                c_exp = (rq.size() > 0 && rq[0].cyc == cyc);
                chk("rd_en", int'(bus.rd_en), int'(c_exp));
                chk("busy", int'(bus.busy), int'(c_exp));
                if (c_exp && bus.rd_en) begin
                    c_b = rq.pop_front();
                    chk("rd_addr", int'(bus.rd_addr), c_b.addr);
                    chk("rd_bank_warm", int'(bus.rd_bank_warm), c_b.warm);
                    chk("rd_bank_dec", int'(bus.rd_bank_dec), c_b.dec);
                end

                while (tq.size() > 0 && tq[0].cyc < cyc) void'(tq.pop_front());
                c_exp = (tq.size() > 0 && tq[0].cyc == cyc);
                chk("tbu_enable", int'(bus.tbu_enable), int'(c_exp));
                if (c_exp && bus.tbu_enable) begin
                    c_b = tq.pop_front();
                    chk("tbu_selection", int'(bus.tbu_selection), int'(c_b.sel));
                end

                while (dq.size() > 0 && dq[0] < cyc) void'(dq.pop_front());
                c_exp = (dq.size() > 0 && dq[0] == cyc);
                chk("block_done", int'(bus.block_done), int'(c_exp));
                if (c_exp) void'(dq.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_rd_en", int'(bus.rd_en), 0);
        chk("rst_rd_addr", int'(bus.rd_addr), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_tbu_enable", int'(bus.tbu_enable), 0);
        chk("rst_tbu_selection", int'(bus.tbu_selection), 0);
        chk("rst_block_done", int'(bus.block_done), 0);
        chk("rst_wr_bank", int'(bus.wr_bank), 0);
        chk("rst_wr_addr", int'(bus.wr_addr), 0);
        chk("rst_wr_en", int'(bus.wr_en), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic drive_random(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1 bus.in_valid = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((rq.size() + tq.size() + dq.size()) != 0 && guard < 300) begin
            @(posedge clk);
            guard++;
        end
        chk("drain_pending", rq.size() + tq.size() + dq.size(), 0);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int guard;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        do_reset();

        // idle after reset
        repeat (50) @(posedge clk);

        // 16 back-to-back writes: one job over banks 1 (warm) and 0 (decode)
        #1 bus.in_valid = 1'b1;
        repeat (16) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (40) @(posedge clk);
        drain();

        // continuous writer, throttled once all four banks are full
        do_reset();
        @(posedge clk);
        #1 bus.in_valid = 1'b1;
        repeat (120) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        drain();

        // random valid gaps
        do_reset();
        drive_random(400);
        drain();

        // reset while decoding, then restart from bank 0
        guard = 0;
        while (!(bus.rd_en && bus.tbu_selection && bus.rd_addr >= 3'd2) && guard < 2000) begin
            @(posedge clk);
            #1 bus.in_valid = ($urandom_range(0, 3) != 0);
            guard++;
        end
        chk("dec_reached", int'(guard < 2000), 1);
        do_reset();
        drive_random(250);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
